// File: rtl/npu_pkg.sv
// ----------------------------------------------------------------------------
// npu_pkg
// Shared types and width helpers for the convolution datapath weight stores.
//   load_state_e  : shadow-bank load state (EMPTY / LOADING / FULL)
//   clog2_min1()  : ceil(log2(n)) clamped to at least one bit
//   kernel_words(): words per kernel (KERNEL_SIZE^2)
//   total_words() : words per bank (KK * NUM_KERNELS)
//   addr_width()  : width of an in-kernel position index (AW)
//   sel_width()   : width of a kernel index (SELW)
// ----------------------------------------------------------------------------
package npu_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      FULL    = 2'd2
   } load_state_e;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int kernel_words(input int kernel_size);
      return kernel_size * kernel_size;
   endfunction

   function automatic int total_words(input int kernel_size, input int num_kernels);
      return kernel_size * kernel_size * num_kernels;
   endfunction

   function automatic int addr_width(input int kernel_size);
      return clog2_min1(kernel_size * kernel_size);
   endfunction

   function automatic int sel_width(input int num_kernels);
      return clog2_min1(num_kernels);
   endfunction

endpackage

// File: rtl/kernel_bank_if.sv
// ----------------------------------------------------------------------------
// kernel_bank_if
// Load stream, swap control and read port of the kernel weight store.
//   load_valid/load_data/load_ready : weight beat stream into the shadow bank
//   load_abort                      : drop a partially loaded shadow bank
//   load_done                       : one-cycle pulse, shadow bank complete
//   swap_req / active_valid         : promote shadow bank / active set present
//   rd_en/rd_kernel/rd_addr         : read request into the active bank
//   rd_data/rd_valid                : registered read response
// master = producer / MAC-array side, slave = kernel_bank.
// ----------------------------------------------------------------------------
interface kernel_bank_if
   import npu_pkg::*;
#(
   parameter int BIT_DEPTH   = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int NUM_KERNELS = 4
) ();

   localparam int AW   = addr_width(KERNEL_SIZE);
   localparam int SELW = sel_width(NUM_KERNELS);

   logic                 load_valid;
   logic [BIT_DEPTH-1:0] load_data;
   logic                 load_ready;
   logic                 load_abort;
   logic                 load_done;
   logic                 swap_req;
   logic                 active_valid;
   logic                 rd_en;
   logic [SELW-1:0]      rd_kernel;
   logic [AW-1:0]        rd_addr;
   logic [BIT_DEPTH-1:0] rd_data;
   logic                 rd_valid;

   modport master (
      output load_valid, load_data, load_abort, swap_req, rd_en, rd_kernel, rd_addr,
      input  load_ready, load_done, active_valid, rd_data, rd_valid
   );

   modport slave (
      input  load_valid, load_data, load_abort, swap_req, rd_en, rd_kernel, rd_addr,
      output load_ready, load_done, active_valid, rd_data, rd_valid
   );

endinterface

// File: rtl/kernel_mem_bank.sv
// ----------------------------------------------------------------------------
// kernel_mem_bank
// One bank of DEPTH x WIDTH weight storage.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
// ----------------------------------------------------------------------------
module kernel_mem_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 36,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage has no reset; the owner gates reads with its own valid flag,
   // so the array can map onto plain RAM/register-file cells.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/kernel_bank.sv
// ----------------------------------------------------------------------------
// kernel_bank
// Double-buffered store of NUM_KERNELS kernels of KERNEL_SIZE x KERNEL_SIZE
// weights. The active bank serves the MAC array while the shadow bank is
// filled over a valid/ready stream; a swap atomically promotes a full shadow.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : kernel_bank_if.slave (load stream, swap, read port)
// ----------------------------------------------------------------------------
module kernel_bank
   import npu_pkg::*;
#(
   parameter int BIT_DEPTH   = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int NUM_KERNELS = 4
) (
   input  logic         clk,
   input  logic         rst,
   kernel_bank_if.slave bus
);

   localparam int KK    = kernel_words(KERNEL_SIZE);
   localparam int TOTAL = total_words(KERNEL_SIZE, NUM_KERNELS);
   localparam int CW    = clog2_min1(TOTAL);

   load_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 done_d;
   logic                 swap;
   logic                 active_bank_q;
   logic                 active_valid_q;
   logic                 load_done_q;
   logic                 accept;
   logic [1:0]           bank_we;
   logic [BIT_DEPTH-1:0] bank_rdata [2];
   logic [CW-1:0]        rd_idx;
   logic                 rd_in_range;
   logic [BIT_DEPTH-1:0] rd_data_q;
   logic                 rd_valid_q;

   // Abort masks ready so an aborted beat is never written.
   assign bus.load_ready = (state_q != FULL) && !bus.load_abort;
   assign accept         = bus.load_valid && bus.load_ready;

   // ---------------- load FSM: next state ----------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      swap    = 1'b0;
      case (state_q)
         EMPTY, LOADING: begin
            if (bus.load_abort) begin
               state_d = EMPTY;
               cnt_d   = '0;
            end else if (accept) begin
               if (cnt_q == CW'(TOTAL - 1)) begin
                  state_d = FULL;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = LOADING;
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         FULL: begin
            // Committed sets are never aborted; only a swap leaves FULL.
            if (bus.swap_req) begin
               swap    = 1'b1;
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // ---------------- load FSM: state register ----------------
   // NOTE: non-blocking assignments for all clocked state so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= EMPTY;
         cnt_q          <= '0;
         active_bank_q  <= 1'b0;
         active_valid_q <= 1'b0;
         load_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         load_done_q <= done_d;
         if (swap) begin
            active_bank_q  <= ~active_bank_q;
            active_valid_q <= 1'b1;
         end
      end
   end

   // ---------------- storage ----------------
   // The bank not pointed at by active_bank_q is the shadow and takes writes.
   assign bank_we[0] = accept &&  active_bank_q;
   assign bank_we[1] = accept && !active_bank_q;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      kernel_mem_bank #(
         .WIDTH (BIT_DEPTH),
         .DEPTH (TOTAL),
         .AW    (CW)
      ) u_bank (
         .clk   (clk),
         .we    (bank_we[b]),
         .waddr (cnt_q),
         .wdata (bus.load_data),
         .raddr (rd_idx),
         .rdata (bank_rdata[b])
      );
   end

   // ---------------- read port ----------------
   always_comb begin
      rd_in_range = (32'(bus.rd_addr) < KK) && (32'(bus.rd_kernel) < NUM_KERNELS);
      // Wraps for out-of-range requests; those are forced to zero below.
      rd_idx      = CW'(32'(bus.rd_kernel) * KK + 32'(bus.rd_addr));
   end

   // A read coinciding with a swap uses the pre-edge bank pointer, i.e. the
   // old active bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) begin
            rd_data_q <= (active_valid_q && rd_in_range) ? bank_rdata[active_bank_q] : '0;
         end
      end
   end

   assign bus.load_done    = load_done_q;
   assign bus.active_valid = active_valid_q;
   assign bus.rd_data      = rd_data_q;
   assign bus.rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_kernel_bank.sv
// ----------------------------------------------------------------------------
// tb_kernel_bank
// Scoreboard bench for kernel_bank (BIT_DEPTH=8, KERNEL_SIZE=3, NUM_KERNELS=2).
// The reference model keeps the shadow bank as a queue of accepted words and
// the active bank as a [kernel][position] array; read expectations are queued
// at issue time and popped by a negedge monitor whenever rd_valid is seen.
// ----------------------------------------------------------------------------
module tb_kernel_bank;

   localparam int BD    = 8;
   localparam int KS    = 3;
   localparam int NK    = 2;
   localparam int KK    = KS * KS;
   localparam int TOTAL = KK * NK;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   kernel_bank_if #(.BIT_DEPTH(BD), .KERNEL_SIZE(KS), .NUM_KERNELS(NK)) bus ();

   kernel_bank #(.BIT_DEPTH(BD), .KERNEL_SIZE(KS), .NUM_KERNELS(NK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // ---------------- reference model / scoreboard ----------------
   int            n_checks = 0;
   int            n_pass   = 0;
   logic [BD-1:0] sb_q[$];
   logic [BD-1:0] shadow_q[$];
   logic [BD-1:0] active_m [NK][KK];
   bit            m_active_valid = 1'b0;
   bit            exp_done       = 1'b0;
   bit            exp_rd_valid   = 1'b0;
   bit            mon_en         = 1'b0;
   logic [BD-1:0] exp_hold       = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: compares DUT outputs against the model on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("rd_valid", bus.rd_valid, exp_rd_valid);
            if (bus.rd_valid) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL rd_data: response with no expected entry, got %0d (t=%0t)",
                           bus.rd_data, $time);
               end else begin
                  exp_hold = sb_q.pop_front();
               end
            end
            check("rd_data", bus.rd_data, exp_hold);
            check("load_done", bus.load_done, exp_done);
            check("active_valid", bus.active_valid, m_active_valid);
         end
      end
   end

   // One clock of stimulus: check combinational ready, take the edge, then
   // advance the model with the inputs that were sampled at that edge.
   task automatic step();
      bit full;
      logic [BD-1:0] rexp;
      #2;
      full = (shadow_q.size() == TOTAL);
      check("load_ready", bus.load_ready, (!full && !bus.load_abort));
      @(posedge clk);
      #1;
      if (bus.rd_en) begin
         rexp = '0;
         if (m_active_valid && int'(bus.rd_addr) < KK && int'(bus.rd_kernel) < NK)
            rexp = active_m[bus.rd_kernel][bus.rd_addr];
         sb_q.push_back(rexp);
      end
      exp_rd_valid = bus.rd_en;
      exp_done     = 1'b0;
      if (!full && bus.load_abort) begin
         shadow_q.delete();
      end else if (!full && bus.load_valid) begin
         shadow_q.push_back(bus.load_data);
         exp_done = (shadow_q.size() == TOTAL);
      end else if (full && bus.swap_req) begin
         for (int k = 0; k < NK; k++)
            for (int a = 0; a < KK; a++)
               active_m[k][a] = shadow_q[k * KK + a];
         shadow_q.delete();
         m_active_valid = 1'b1;
      end
   endtask

   task automatic drive(input bit lv, input int ld, input bit la, input bit sw,
                        input bit re, input int rk, input int ra);
      bus.load_valid = lv;
      bus.load_data  = BD'(ld);
      bus.load_abort = la;
      bus.swap_req   = sw;
      bus.rd_en      = re;
      bus.rd_kernel  = 1'(rk);
      bus.rd_addr    = 4'(ra);
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      mon_en         = 1'b0;
      rst            = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bus.load_abort = 1'b0;
      bus.swap_req   = 1'b0;
      bus.rd_en      = 1'b0;
      bus.rd_kernel  = '0;
      bus.rd_addr    = '0;
      sb_q.delete();
      shadow_q.delete();
      m_active_valid = 1'b0;
      exp_done       = 1'b0;
      exp_rd_valid   = 1'b0;
      exp_hold       = '0;
      #2;
      check("rst_load_ready", bus.load_ready, 1);
      check("rst_load_done", bus.load_done, 0);
      check("rst_active_valid", bus.active_valid, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rd_data", bus.rd_data, 0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Read before any set is committed: zero data, valid one cycle later.
      drive(0, 0, 0, 0, 1, 0, 4);
      idle(2);

      // Set A = 1..18, with a swap request while LOADING that must be ignored.
      for (int i = 1; i <= TOTAL; i++) drive(1, i, 0, (i == 5), 0, 0, 0);
      drive(1, 19, 0, 0, 0, 0, 0);            // refused while FULL
      drive(0, 0, 0, 1, 0, 0, 0);             // swap
      drive(0, 0, 0, 0, 1, 1, 8);             // expect 18
      drive(0, 0, 0, 0, 1, 0, 0);             // expect 1
      idle(1);

      // Set B = 101..118, valid every other cycle, reads of A throughout.
      begin
         int beat = 1;
         int cyc  = 0;
         while (beat <= TOTAL) begin
            bit lv = (cyc % 2 == 0);
            drive(lv, beat + 100, 0, (beat == 9), 1,
                  $urandom_range(NK - 1), $urandom_range(KK - 1));
            if (lv) beat++;
            cyc++;
         end
      end
      drive(0, 0, 0, 1, 1, 0, 0);             // same-cycle swap: old data (1)
      drive(0, 0, 0, 0, 1, 0, 0);             // new bank: 101
      drive(0, 0, 0, 0, 1, 1, 9);             // out of range: 0
      drive(0, 0, 0, 0, 1, 1, 15);            // out of range: 0
      idle(3);                                // rd_data holds

      // Abort after 5 beats (abort wins over a same-cycle beat), then reload.
      for (int i = 0; i < 5; i++) drive(1, $urandom_range(255), 0, 0, 0, 0, 0);
      drive(1, 8'hEE, 1, 0, 0, 0, 0);
      for (int i = 0; i < TOTAL; i++) drive(1, $urandom_range(255), 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < NK; k++)
         for (int a = 0; a < KK; a++) drive(0, 0, 0, 0, 1, k, a);
      idle(1);

      // Randomised traffic over all controls.
      for (int i = 0; i < 800; i++)
         drive($urandom_range(1), $urandom_range(255), ($urandom_range(19) == 0),
               ($urandom_range(3) == 0), $urandom_range(1),
               $urandom_range(NK - 1), $urandom_range(15));
      idle(2);

      // Reset in the middle of a load and a read.
      for (int i = 0; i < 3; i++) drive(1, $urandom_range(255), 0, 0, 0, 0, 0);
      drive(1, 77, 0, 0, 1, 0, 0);
      do_reset();
      drive(0, 0, 0, 0, 1, 0, 0);             // no committed set: 0
      for (int i = 1; i <= TOTAL; i++) drive(1, i + 200, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 1, 8);             // still not swapped: 0
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 0);             // 201
      drive(0, 0, 0, 0, 1, 1, 8);             // 218
      drive(1, 50, 0, 0, 0, 0, 0);            // back-to-back load after swap
      idle(3);

      check("sb_drain", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
